// File: rtl/sort_insert_ctrl.sv
// Insert sequencer for the systolic sort-cell array: accepts records, broadcasts them,
// and steps the cells through compare / latch / shift phases while tracking occupancy.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for a record or a pending clear
//   S_PLACE | comparators enabled, held CMP_LAT cycles
//   S_WREN  | cells latch their compare result
//   S_ORDER | cells shift/insert; next record may be accepted here
//   S_CLEAR | one-cycle array flush
module sort_insert_ctrl #(
  parameter int SORT_WIDTH = 32,
  parameter int NUM_CELLS  = 16,
  parameter int CMP_LAT    = 1,
  parameter int CNT_W      = $clog2(NUM_CELLS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SORT_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  clear,
  output logic [SORT_WIDTH-1:0] cell_datain,
  output logic                  cell_place_en,
  output logic                  cell_wren,
  output logic                  cell_order,
  output logic                  cell_clr,
  output logic [CNT_W-1:0]      fill_count,
  output logic                  busy,
  output logic                  batch_done
);

  localparam int LAT   = (CMP_LAT < 1) ? 1 : CMP_LAT;
  localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_WREN,
    S_ORDER,
    S_CLEAR
  } state_e;

  state_e                  state_q, state_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [SORT_WIDTH-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic                    clr_pend_q, clr_pend_d;
  logic                    done_q, done_d;
  logic                    boundary;
  logic                    xfer;

  // Accept only at an insert boundary; a same-cycle clear pulse wins over the record.
  assign boundary = (state_q == S_IDLE) || (state_q == S_ORDER);
  assign in_ready = boundary && !clr_pend_q && !clear && !reset;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    data_d     = data_q;
    last_d     = last_q;
    fill_d     = fill_q;
    clr_pend_d = clr_pend_q | clear;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_pend_q) begin
          state_d = S_CLEAR;
        end else if (xfer) begin
          state_d = S_PLACE;
          data_d  = in_data;
          last_d  = in_last;
          lat_d   = LAT_W'(LAT - 1);
        end
      end
      S_PLACE: begin
        if (lat_q == '0) begin
          state_d = S_WREN;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_WREN: begin
        state_d = S_ORDER;
      end
      S_ORDER: begin
        if (fill_q != CNT_W'(NUM_CELLS)) begin
          fill_d = fill_q + CNT_W'(1);
        end
        done_d = last_q;
        if (clr_pend_q) begin
          state_d = S_CLEAR;
        end else if (xfer) begin
          state_d = S_PLACE;
          data_d  = in_data;
          last_d  = in_last;
          lat_d   = LAT_W'(LAT - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        fill_d     = '0;
        clr_pend_d = clear;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      fill_q     <= '0;
      clr_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      data_q     <= data_d;
      last_q     <= last_d;
      fill_q     <= fill_d;
      clr_pend_q <= clr_pend_d;
      done_q     <= done_d;
    end
  end

  // Outputs are forced quiet while reset is held so an aborted insert emits nothing.
  assign cell_datain   = reset ? '0 : data_q;
  assign cell_place_en = (state_q == S_PLACE) && !reset;
  assign cell_wren     = (state_q == S_WREN)  && !reset;
  assign cell_order    = (state_q == S_ORDER) && !reset;
  assign cell_clr      = (state_q == S_CLEAR) && !reset;
  assign busy          = (state_q != S_IDLE)  && !reset;
  assign fill_count    = reset ? '0 : fill_q;
  assign batch_done    = done_q && !reset;

endmodule

// File: tb/tb_sort_insert_ctrl.sv
// Scoreboard bench for sort_insert_ctrl: a timing-schedule model predicts handshakes and
// strobes, accepted records queue up and a monitor matches them to order/clear pulses.
module tb_sort_insert_ctrl;
  localparam int SW  = 32;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int CW  = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          clear = 1'b0;
  logic [SW-1:0] cell_datain;
  logic          cell_place_en, cell_wren, cell_order, cell_clr;
  logic [CW-1:0] fill_count;
  logic          busy, batch_done;

  sort_insert_ctrl #(.SORT_WIDTH(SW), .NUM_CELLS(N), .CMP_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clear(clear),
    .cell_datain(cell_datain), .cell_place_en(cell_place_en), .cell_wren(cell_wren),
    .cell_order(cell_order), .cell_clr(cell_clr), .fill_count(fill_count),
    .busy(busy), .batch_done(batch_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [SW-1:0] data;
    logic          last;
    int            cyc;
  } rec_t;

  rec_t ins_q[$];
  int   clr_q[$];

  // schedule model: age = cycles since acceptance of the in-flight record (-1 = none)
  int age = -1;
  bit clr_now = 0;
  bit pend = 0;
  bit last_acc = 0;

  // monitor-side model
  bit mon_en = 0;
  int fill_m = 0;
  bit bd_exp = 0;
  bit chk_fill = 0;
  int fill_exp = 0;

  bit            have_rec = 0;
  logic [SW-1:0] rec_d;
  bit            rec_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input logic [SW-1:0] d, input bit l, input bit c);
    bit boundary, rdy, go_clr;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; clear = c;
    #1;
    boundary = (age < 0 && !clr_now) || (age == LAT + 2);
    rdy      = boundary && !pend && !c;
    chk("in_ready", in_ready, rdy);
    chk("place_en", cell_place_en, (age >= 1 && age <= LAT));
    chk("wren", cell_wren, (age == LAT + 1));
    chk("busy", busy, (age > 0 || clr_now));
    last_acc = v && rdy;
    if (last_acc) ins_q.push_back('{d, l, cyc});
    if (clr_now) begin
      clr_now = 0;
      pend    = c;
    end else begin
      go_clr = boundary && pend;
      pend   = pend | c;
      if (go_clr) begin
        clr_now = 1;
        age     = -1;
        clr_q.push_back(cyc + 1);
      end else if (last_acc) age = 1;
      else if (age >= 1 && age <= LAT + 1) age++;
      else age = -1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0);
  endtask

  task automatic send(input logic [SW-1:0] d, input bit l);
    int k = 0;
    do begin
      drive(1, d, l, 0);
      k++;
    end while (!last_acc && k < 40);
    if (!last_acc) chk("send_accept", 0, 1);
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk);
    reset = 1; in_valid = 1; in_data = $urandom; clear = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobes", {cell_place_en, cell_wren, cell_order, cell_clr}, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("rst_fill", fill_count, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_datain", cell_datain, 0);
    chk("rst_strobes2", {cell_place_en, cell_wren, cell_order, cell_clr}, 0);
    reset = 0; in_valid = 0;
    #1;
    chk("rst_idle_busy", busy, 0);
    age = -1; clr_now = 0; pend = 0; have_rec = 0;
    ins_q.delete(); clr_q.delete();
    fill_m = 0; bd_exp = 0; chk_fill = 0;
    mon_en = 1;
  endtask

  initial begin
    rec_t r;
    int c;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("batch_done", batch_done, bd_exp);
        bd_exp = 0;
        if (chk_fill) chk("fill_count", fill_count, fill_exp);
        chk_fill = 0;
        chk("strobe_onehot",
            ($countones({cell_place_en, cell_wren, cell_order, cell_clr}) <= 1), 1);
        if ((cell_place_en || cell_wren || cell_order) && ins_q.size() > 0)
          chk("cell_datain", cell_datain, ins_q[0].data);
        if (cell_order) begin
          if (ins_q.size() == 0) begin
            chk("order_unexpected", 1, 0);
          end else begin
            r = ins_q.pop_front();
            chk("order_latency", cyc - r.cyc, LAT + 2);
            fill_m   = (fill_m < N) ? fill_m + 1 : N;
            fill_exp = fill_m;
            chk_fill = 1;
            bd_exp   = r.last;
          end
        end
        if (cell_clr) begin
          if (clr_q.size() == 0) begin
            chk("clr_unexpected", 1, 0);
          end else begin
            c = clr_q.pop_front();
            chk("clr_cycle", cyc, c);
            fill_m   = 0;
            fill_exp = 0;
            chk_fill = 1;
          end
        end
      end
    end
  end

  initial begin
    do_reset();
    // single record, then back-to-back stream with saturation
    send(32'h3F80_0000, 0);
    idle(8);
    for (int i = 0; i < 6; i++) send($urandom, (i == 5));
    idle(8);
    // clear during PLACE of an in-flight record
    send(32'hA5A5_0001, 1);
    drive(0, '0, 0, 1);
    idle(10);
    // clear re-armed while CLEAR is active
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
    drive(0, '0, 0, 1);
    idle(8);
    // reset landing in WREN
    send(32'h1234_5678, 0);
    idle(6);
    send(32'hDEAD_BEEF, 1);
    while (age != LAT + 1) drive(0, '0, 0, 0);
    do_reset();
    idle(4);
    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (!have_rec && $urandom_range(9) < 6) begin
        have_rec = 1;
        rec_d    = $urandom;
        rec_l    = ($urandom_range(4) == 0);
      end
      drive(have_rec, rec_d, rec_l, ($urandom_range(24) == 0));
      if (last_acc) have_rec = 0;
    end
    idle(20);
    chk("ins_q_drained", ins_q.size(), 0);
    chk("clr_q_drained", clr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
